dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Sequences and shares the single-ported data memory between two requesters: the pipeline MEM stage (CPU) and a DMA/peripheral master.
- Fixed-priority arbitration (CPU first) with a bounded-starvation override for the DMA.
- Holds the CPU pipeline via a stall line while an access is in flight.
- Sits between EX/MEM outputs, the data memory, and the DMA engine.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 2, cycles a memory access occupies (>=1)
MAX_WAIT, 3, consecutive CPU grants over a pending DMA request before DMA is forced (>=1)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
cpu_req  in  1  MEM stage requests access (MemRead or MemWrite)
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  CPU byte address
cpu_wdata  in  DATA_W  CPU store data
cpu_rdata  out  DATA_W  CPU load data, valid while cpu_stall=0 in the done cycle
cpu_stall  out  1  freeze PC/IF_ID/ID_EX/EX_MEM, insert bubble into MEM_WB
dma_req  in  1  DMA requests access, held until dma_ack
dma_we  in  1  1=write, 0=read
dma_addr  in  ADDR_W  DMA address
dma_wdata  in  DATA_W  DMA store data
dma_rdata  out  DATA_W  DMA load data, valid with dma_ack
dma_ack  out  1  one-cycle completion pulse to DMA
mem_addr  out  ADDR_W  to data memory
mem_wdata  out  DATA_W  to data memory
mem_rd  out  1  memory read enable
mem_wr  out  1  memory write enable
mem_rdata  in  DATA_W  memory read data (combinational read)
owner  out  1  0=CPU, 1=DMA; current/last grantee

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, owner=0, wait_cnt=0, lat_cnt=0, mem_rd=mem_wr=0, dma_ack=0, cpu_rdata=dma_rdata=0, latched addr/wdata/we=0; cpu_stall forced 0.
- States: IDLE, ACCESS, RESP.
- IDLE, no request: outputs idle.
- IDLE, request present, arbitration:
  - DMA wins iff dma_req && (!cpu_req || wait_cnt==MAX_WAIT); otherwise CPU wins.
  - Winner's we/addr/wdata latched, owner set, lat_cnt=MEM_LAT-1, next=ACCESS.
  - wait_cnt: +1 (saturating at MAX_WAIT) when CPU granted while dma_req=1; cleared when DMA granted; unchanged otherwise.
- ACCESS:
  - mem_addr/mem_wdata driven from latched values.
  - mem_rd=!we for every ACCESS cycle.
  - mem_wr=we only on the final ACCESS cycle (lat_cnt==0), so exactly one write per access.
  - lat_cnt decrements each cycle.
  - Final cycle: mem_rdata captured into cpu_rdata or dma_rdata per owner (reads only; the other register is unchanged); next=RESP.
  - MEM_LAT=1: a single ACCESS cycle that is both first and final.
- RESP (one cycle):
  - owner=DMA: dma_ack=1.
  - owner=CPU: cpu_stall=0 this cycle, so the pipeline advances at the next edge.
  - next=IDLE unconditionally; requests seen in RESP are ignored (the CPU request there is the completed one).
- cpu_stall (combinational) = reset && cpu_req && !(state==RESP && owner==0). The stall asserts in the same cycle cpu_req first appears.
- CPU load latency: req at cycle t (IDLE) → data and stall low at t+MEM_LAT+1. Throughput: one access per MEM_LAT+2 cycles.
- mem_addr/mem_wdata hold latched values outside ACCESS (no glitching to the inputs); mem_rd/mem_wr are 0 outside ACCESS.
- Requester drops req mid-access: the access completes, and ack/stall-release still occur. Inputs are not re-sampled after the grant.
- Simultaneous cpu_req and dma_req with wait_cnt<MAX_WAIT: CPU granted, wait_cnt+1.
- Reset asserted mid-ACCESS before the final cycle: no write is issued, no ack, state returns to IDLE.
- Addresses are passed through unmodified; byte extraction stays in the MEM stage.

Test Plan:
1. MEM_LAT=2. CPU read addr 0x10, memory returns 0x0000_00AB → cpu_stall high 3 cycles, mem_rd high 2 cycles, cpu_rdata=0xAB in the RESP cycle, stall low there.
2. CPU write 0x20←0xDEADBEEF → mem_wr high exactly 1 cycle (second ACCESS cycle), with addr 0x20 and data 0xDEADBEEF; no dma_ack.
3. DMA read 0x40 alone, memory returns 0x1234 → dma_ack one pulse 3 cycles after grant, dma_rdata=0x1234, cpu_stall stays 0.
4. MAX_WAIT=3. dma_req held with cpu_req continuously asserted for four back-to-back CPU accesses → grants CPU,CPU,CPU,DMA; wait_cnt 1,2,3,0.
5. Reset pulled low during the first ACCESS cycle of a DMA write → mem_wr never asserts, dma_ack=0, all outputs at reset values, IDLE after release.
6. MEM_LAT=1. CPU read then immediate CPU write → each access takes 3 cycles; mem_rd and mem_wr each 1 cycle; no overlap.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Shares the single-ported data memory between the CPU MEM stage and a DMA master.
// CPU has fixed priority; a DMA request waiting MAX_WAIT CPU grants is forced through.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MEM_LAT  = 2,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner
);

  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [LW-1:0] LAT_INIT = LW'(MEM_LAT - 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} stateT;

  stateT             stateReg;
  stateT             stateNext;
  logic [LW-1:0]     latCnt;
  logic [WW-1:0]     waitCnt;
  logic              latWe;
  logic [ADDR_W-1:0] latAddr;
  logic [DATA_W-1:0] latWdata;
  logic              anyReq;
  logic              dmaWins;
  logic              lastCycle;

  assign anyReq    = cpu_req | dma_req;
  assign dmaWins   = dma_req & (~cpu_req | (waitCnt == WAIT_MAX));
  assign lastCycle = (latCnt == '0);

  // Memory bus holds the latched request so it never follows live requester inputs.
  assign mem_addr  = latAddr;
  assign mem_wdata = latWdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (anyReq) stateNext = ACCESS;
      ACCESS:  if (lastCycle) stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    dma_ack   = 1'b0;
    // The completed CPU request is still present in RESP; release it there only.
    cpu_stall = reset & cpu_req & ~((stateReg == RESP) & ~owner);
    case (stateReg)
      ACCESS: begin
        mem_rd = ~latWe;
        mem_wr = latWe & lastCycle;
      end
      RESP:    dma_ack = owner;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner     <= 1'b0;
      waitCnt   <= '0;
      latCnt    <= '0;
      latWe     <= 1'b0;
      latAddr   <= '0;
      latWdata  <= '0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (anyReq) begin
            owner    <= dmaWins;
            latWe    <= dmaWins ? dma_we    : cpu_we;
            latAddr  <= dmaWins ? dma_addr  : cpu_addr;
            latWdata <= dmaWins ? dma_wdata : cpu_wdata;
            latCnt   <= LAT_INIT;
            if (dmaWins) begin
              waitCnt <= '0;
            end else if (dma_req && waitCnt != WAIT_MAX) begin
              waitCnt <= waitCnt + 1'b1;
            end
          end
        end
        ACCESS: begin
          if (!lastCycle) begin
            latCnt <= latCnt - 1'b1;
          end else if (!latWe) begin
            if (owner) begin
              dma_rdata <= mem_rdata;
            end else begin
              cpu_rdata <= mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: instance A at MEM_LAT=2, instance B at MEM_LAT=1.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        cpu_req, cpu_we, cpu_stall;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_ack;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr, owner;

  logic        bCpuReq, bCpuWe, bCpuStall;
  logic [31:0] bCpuAddr, bCpuWdata, bCpuRdata;
  logic        bDmaReq, bDmaWe, bDmaAck;
  logic [31:0] bDmaAddr, bDmaWdata, bDmaRdata;
  logic [31:0] bMemAddr, bMemWdata, bMemRdata;
  logic        bMemRd, bMemWr, bOwner;

  logic [31:0] memA [0:63];
  logic [31:0] memB [0:63];

  assign mem_rdata = memA[mem_addr[7:2]];
  assign bMemRdata = memB[bMemAddr[7:2]];
  always @(posedge clk) if (mem_wr) memA[mem_addr[7:2]] <= mem_wdata;
  always @(posedge clk) if (bMemWr) memB[bMemAddr[7:2]] <= bMemWdata;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .MAX_WAIT(3)) dutA (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_WAIT(3)) dutB (
    .clk(clk), .reset(reset),
    .cpu_req(bCpuReq), .cpu_we(bCpuWe), .cpu_addr(bCpuAddr), .cpu_wdata(bCpuWdata),
    .cpu_rdata(bCpuRdata), .cpu_stall(bCpuStall),
    .dma_req(bDmaReq), .dma_we(bDmaWe), .dma_addr(bDmaAddr), .dma_wdata(bDmaWdata),
    .dma_rdata(bDmaRdata), .dma_ack(bDmaAck),
    .mem_addr(bMemAddr), .mem_wdata(bMemWdata), .mem_rd(bMemRd), .mem_wr(bMemWr),
    .mem_rdata(bMemRdata), .owner(bOwner)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } expT;

  expT cpuQ[$];
  expT dmaQ[$];
  expT monE;
  int  checks = 0;
  int  errors = 0;

  // Scoreboard for instance A: pop on CPU stall release or DMA ack.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (cpu_req && !cpu_stall) begin
        checks++;
        if (cpuQ.size() == 0) begin
          errors++;
          $display("FAIL sb_cpu_unexpected got completion want none");
        end else begin
          monE = cpuQ.pop_front();
          if (monE.we && memA[monE.addr[7:2]] !== monE.data) begin
            errors++;
            $display("FAIL sb_cpu_write addr %h got %h want %h", monE.addr, memA[monE.addr[7:2]], monE.data);
          end else if (!monE.we && cpu_rdata !== monE.data) begin
            errors++;
            $display("FAIL sb_cpu_read addr %h got %h want %h", monE.addr, cpu_rdata, monE.data);
          end else begin
            $display("sb cpu %s addr %h data %h ok", monE.we ? "wr" : "rd", monE.addr, monE.data);
          end
        end
      end
      if (dma_ack) begin
        checks++;
        if (dmaQ.size() == 0) begin
          errors++;
          $display("FAIL sb_dma_unexpected got ack want none");
        end else begin
          monE = dmaQ.pop_front();
          if (monE.we && memA[monE.addr[7:2]] !== monE.data) begin
            errors++;
            $display("FAIL sb_dma_write addr %h got %h want %h", monE.addr, memA[monE.addr[7:2]], monE.data);
          end else if (!monE.we && dma_rdata !== monE.data) begin
            errors++;
            $display("FAIL sb_dma_read addr %h got %h want %h", monE.addr, dma_rdata, monE.data);
          end else begin
            $display("sb dma %s addr %h data %h ok", monE.we ? "wr" : "rd", monE.addr, monE.data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    bCpuReq = 1'b0; bCpuWe = 1'b0; bCpuAddr = '0; bCpuWdata = '0;
    bDmaReq = 1'b0; bDmaWe = 1'b0; bDmaAddr = '0; bDmaWdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mem_rd, mem_wr, dma_ack, owner, cpu_stall} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00000", {mem_rd, mem_wr, dma_ack, owner, cpu_stall});
    end
    checks++;
    if ({cpu_rdata, dma_rdata, mem_addr, mem_wdata} !== 128'b0) begin
      errors++;
      $display("FAIL reset_data got %h %h %h %h want 0", cpu_rdata, dma_rdata, mem_addr, mem_wdata);
    end
    $display("reset checked");
    tick();
    cpu_req = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_cpu_read();
    int stallCnt = 0, rdCnt = 0;
    bit done = 0;
    memA[4] <= 32'h0000_00AB;
    tick();
    cpu_we = 1'b0; cpu_addr = 32'h10; cpu_req = 1'b1;
    cpuQ.push_back({1'b0, 32'h10, 32'h0000_00AB});
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (cpu_stall) stallCnt++;
      if (mem_rd) rdCnt++;
      if (!cpu_stall) begin
        done = 1;
        checks++;
        if (cpu_rdata !== 32'h0000_00AB) begin
          errors++;
          $display("FAIL cpu_read_data got %h want 000000ab", cpu_rdata);
        end
      end else begin
        tick();
      end
    end
    tick();
    cpu_req = 1'b0;
    checks++;
    if (!done) begin errors++; $display("FAIL cpu_read_timeout got none want done"); end
    checks++;
    if (stallCnt != 3) begin errors++; $display("FAIL cpu_read_stall got %0d want 3", stallCnt); end
    checks++;
    if (rdCnt != 2) begin errors++; $display("FAIL cpu_read_memrd got %0d want 2", rdCnt); end
    $display("cpu read 0x10 stall %0d rd %0d", stallCnt, rdCnt);
  endtask

  task automatic test_cpu_write();
    int wrCnt = 0, rdCnt = 0, ackCnt = 0, wrCyc = -1;
    logic [31:0] wrAddr = '0, wrData = '0;
    bit done = 0;
    memA[8] <= 32'h0;
    tick();
    cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'hDEAD_BEEF; cpu_req = 1'b1;
    cpuQ.push_back({1'b1, 32'h20, 32'hDEAD_BEEF});
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (mem_wr) begin wrCnt++; wrCyc = c; wrAddr = mem_addr; wrData = mem_wdata; end
      if (mem_rd) rdCnt++;
      if (dma_ack) ackCnt++;
      if (!cpu_stall) done = 1;
      else tick();
    end
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
    checks++;
    if (!done) begin errors++; $display("FAIL cpu_write_timeout got none want done"); end
    checks++;
    if (wrCnt != 1) begin errors++; $display("FAIL cpu_write_count got %0d want 1", wrCnt); end
    checks++;
    if (wrCyc != 2) begin errors++; $display("FAIL cpu_write_cycle got %0d want 2", wrCyc); end
    checks++;
    if (wrAddr !== 32'h20 || wrData !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL cpu_write_bus got %h/%h want 00000020/deadbeef", wrAddr, wrData);
    end
    checks++;
    if (rdCnt != 0 || ackCnt != 0) begin
      errors++;
      $display("FAIL cpu_write_side got rd %0d ack %0d want 0 0", rdCnt, ackCnt);
    end
    $display("cpu write 0x20 wr %0d at cycle %0d", wrCnt, wrCyc);
  endtask

  task automatic test_dma_read();
    int ackCnt = 0, ackCyc = -1, stallCnt = 0;
    memA[16] <= 32'h0000_1234;
    tick();
    dma_we = 1'b0; dma_addr = 32'h40; dma_req = 1'b1;
    dmaQ.push_back({1'b0, 32'h40, 32'h0000_1234});
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (cpu_stall) stallCnt++;
      if (dma_ack) begin
        ackCnt++;
        ackCyc = c;
        checks++;
        if (dma_rdata !== 32'h0000_1234) begin
          errors++;
          $display("FAIL dma_read_data got %h want 00001234", dma_rdata);
        end
      end
      tick();
      if (ackCnt > 0) dma_req = 1'b0;
    end
    checks++;
    if (ackCnt != 1) begin errors++; $display("FAIL dma_ack_count got %0d want 1", ackCnt); end
    checks++;
    if (ackCyc != 3) begin errors++; $display("FAIL dma_ack_cycle got %0d want 3", ackCyc); end
    checks++;
    if (stallCnt != 0) begin errors++; $display("FAIL dma_cpu_stall got %0d want 0", stallCnt); end
    $display("dma read 0x40 ack %0d at cycle %0d", ackCnt, ackCyc);
  endtask

  task automatic test_back_to_back();
    logic gq[$];
    logic expG [5];
    logic prevRd = 1'b0;
    bit dropDma, cpuFin;
    int cpuDone = 0;
    expG = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) memA[32 + i] <= 32'h100 + i;
    memA[48] <= 32'h0000_5A5A;
    tick();
    cpu_we = 1'b0; cpu_addr = 32'h80; cpu_req = 1'b1;
    cpuQ.push_back({1'b0, 32'h80, 32'h100});
    dma_we = 1'b0; dma_addr = 32'hC0; dma_req = 1'b1;
    dmaQ.push_back({1'b0, 32'hC0, 32'h0000_5A5A});
    for (int c = 0; c < 80 && cpuDone < 4; c++) begin
      @(negedge clk);
      if (mem_rd && !prevRd) gq.push_back(owner);
      prevRd = mem_rd;
      dropDma = dma_ack;
      cpuFin = cpu_req && !cpu_stall;
      if (cpuFin) cpuDone++;
      tick();
      if (dropDma) dma_req = 1'b0;
      if (cpuFin) begin
        if (cpuDone < 4) begin
          cpu_addr = 32'h80 + 32'(4 * cpuDone);
          cpuQ.push_back({1'b0, 32'h80 + 32'(4 * cpuDone), 32'h100 + 32'(cpuDone)});
        end else begin
          cpu_req = 1'b0;
        end
      end
    end
    dma_req = 1'b0;
    cpu_req = 1'b0;
    checks++;
    if (gq.size() != 5) begin errors++; $display("FAIL b2b_grant_count got %0d want 5", gq.size()); end
    for (int i = 0; i < gq.size() && i < 5; i++) begin
      checks++;
      if (gq[i] !== expG[i]) begin
        errors++;
        $display("FAIL b2b_grant_%0d got owner %b want %b", i, gq[i], expG[i]);
      end
    end
    $display("back-to-back grants %0d cpu done %0d", gq.size(), cpuDone);
  endtask

  task automatic test_reset_mid_access();
    int wrSeen = 0, activity = 0;
    memA[24] <= 32'h1111_1111;
    tick();
    dma_we = 1'b1; dma_addr = 32'h60; dma_wdata = 32'hCAFE_F00D; dma_req = 1'b1;
    @(negedge clk);
    if (mem_wr) wrSeen++;
    tick();
    checks++;
    if (owner !== 1'b1) begin errors++; $display("FAIL rst_mid_owner got %b want 1", owner); end
    reset = 1'b0; cpu_req = 1'b1; dma_req = 1'b0;
    @(negedge clk);
    if (mem_wr) wrSeen++;
    checks++;
    if ({mem_rd, mem_wr, dma_ack, owner, cpu_stall} !== 5'b0) begin
      errors++;
      $display("FAIL rst_mid_ctrl got %b want 00000", {mem_rd, mem_wr, dma_ack, owner, cpu_stall});
    end
    checks++;
    if ({cpu_rdata, dma_rdata, mem_addr, mem_wdata} !== 128'b0) begin
      errors++;
      $display("FAIL rst_mid_data got %h %h %h %h want 0", cpu_rdata, dma_rdata, mem_addr, mem_wdata);
    end
    tick();
    tick();
    reset = 1'b1; cpu_req = 1'b0; dma_we = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (mem_wr) wrSeen++;
      if (mem_rd || dma_ack) activity++;
      tick();
    end
    checks++;
    if (wrSeen != 0) begin errors++; $display("FAIL rst_mid_write got %0d want 0", wrSeen); end
    checks++;
    if (activity != 0) begin errors++; $display("FAIL rst_mid_activity got %0d want 0", activity); end
    checks++;
    if (memA[24] !== 32'h1111_1111) begin errors++; $display("FAIL rst_mid_mem got %h want 11111111", memA[24]); end
    checks++;
    if (dutA.stateReg !== 2'd0) begin errors++; $display("FAIL rst_mid_state got %0d want 0", dutA.stateReg); end
    $display("reset mid-access writes %0d activity %0d", wrSeen, activity);
  endtask

  task automatic test_memlat1();
    int lens [2];
    int phase = 0, cyc = 0, rdCnt = 0, wrCnt = 0, overlap = 0;
    lens = '{0, 0};
    memB[4] <= 32'h0000_0077;
    memB[5] <= 32'h0;
    tick();
    bCpuWe = 1'b0; bCpuAddr = 32'h10; bCpuReq = 1'b1;
    for (int c = 0; c < 30 && phase < 2; c++) begin
      @(negedge clk);
      cyc++;
      if (bMemRd) rdCnt++;
      if (bMemWr) wrCnt++;
      if (bMemRd && bMemWr) overlap++;
      if (bCpuReq && !bCpuStall) begin
        lens[phase] = cyc;
        if (phase == 0) begin
          checks++;
          if (bCpuRdata !== 32'h0000_0077) begin
            errors++;
            $display("FAIL lat1_read_data got %h want 00000077", bCpuRdata);
          end
        end
        phase++;
        cyc = 0;
        tick();
        if (phase == 1) begin
          bCpuWe = 1'b1; bCpuAddr = 32'h14; bCpuWdata = 32'h0000_0099;
        end else begin
          bCpuReq = 1'b0;
        end
      end else begin
        tick();
      end
    end
    checks++;
    if (phase != 2) begin errors++; $display("FAIL lat1_timeout got %0d want 2", phase); end
    checks++;
    if (lens[0] != 3 || lens[1] != 3) begin
      errors++;
      $display("FAIL lat1_cycles got %0d/%0d want 3/3", lens[0], lens[1]);
    end
    checks++;
    if (rdCnt != 1 || wrCnt != 1 || overlap != 0) begin
      errors++;
      $display("FAIL lat1_strobes got rd %0d wr %0d ov %0d want 1 1 0", rdCnt, wrCnt, overlap);
    end
    checks++;
    if (memB[5] !== 32'h0000_0099) begin errors++; $display("FAIL lat1_mem got %h want 00000099", memB[5]); end
    $display("memlat1 read+write cycles %0d/%0d", lens[0], lens[1]);
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_dma_read();
    test_back_to_back();
    test_reset_mid_access();
    test_memlat1();
    repeat (2) tick();
    checks++;
    if (cpuQ.size() != 0 || dmaQ.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got cpu %0d dma %0d want 0 0", cpuQ.size(), dmaQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
